// File: rtl/multicycle_divider.sv
// multicycle_divider
//   Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//   One operation in flight at a time. The quotient goes to LO and the
//   remainder goes to HI. Latency is WIDTH+1 cycles, or 1 cycle on a
//   divide by zero.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   start          request a divide (sampled in IDLE only)
//   signed_op      1 = DIV (signed), 0 = DIVU; sampled with start
//   dividend       numerator; sampled with start
//   divisor        denominator; sampled with start
//   cancel         pipeline flush; abort and return to IDLE
//   result_ack     EX consumed the result; leaves DONE
//   stall_request  combinational pipeline hold while a divide is in flight
//   done           quotient/remainder valid
//   quotient       result to LO
//   remainder      result to HI
module multicycle_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   input  logic             result_ack,
   output logic             stall_request,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd_q;    // dividend magnitude; MSB feeds each step
   logic [WIDTH-1:0] dvs_q;    // divisor magnitude
   logic [WIDTH-1:0] prem_q;   // partial remainder (always < divisor)
   logic [WIDTH-1:0] quo_q;    // quotient bits collected so far
   logic [CW-1:0]    cnt_q;
   logic             q_neg_q;
   logic             r_neg_q;

   // Operand magnitudes. The most-negative value wraps to itself, so the
   // signed-overflow case produces the most-negative quotient with no
   // special handling.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = signed_op & dividend[WIDTH-1];
   assign b_neg = signed_op & divisor[WIDTH-1];
   assign a_mag = a_neg ? (~dividend + ONE) : dividend;
   assign b_mag = b_neg ? (~divisor + ONE) : divisor;

   // One restoring step. rem_sh is the (WIDTH+1)-bit shifted remainder.
   // Because rem_sh < 2*divisor, the borrow out of the subtraction is
   // exactly the "does not fit" condition.
   logic [WIDTH:0]   rem_sh, diff;
   logic             fits;
   logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;
   logic             last;

   assign rem_sh = {prem_q, dvd_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign fits   = ~diff[WIDTH];
   assign rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nx = {quo_q[WIDTH-2:0], fits};
   assign last   = (cnt_q == CW'(WIDTH - 1));
   assign q_fin  = q_neg_q ? (~quo_nx + ONE) : quo_nx;
   assign r_fin  = r_neg_q ? (~rem_nx + ONE) : rem_nx;

   assign stall_request = ((state == IDLE) & start & ~cancel) | (state == BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         prem_q    <= '0;
         quo_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
      end else if (cancel) begin
         // Flush: results hold their last value, only the control state clears.
         state <= IDLE;
         done  <= 1'b0;
         cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     dvd_q   <= a_mag;
                     dvs_q   <= b_mag;
                     prem_q  <= '0;
                     quo_q   <= '0;
                     q_neg_q <= a_neg ^ b_neg;
                     r_neg_q <= a_neg;
                     cnt_q   <= '0;
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
               prem_q <= rem_nx;
               quo_q  <= quo_nx;
               cnt_q  <= cnt_q + CW'(1);
               if (last) begin
                  quotient  <= q_fin;
                  remainder <= r_fin;
                  done      <= 1'b1;
                  cnt_q     <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (result_ack) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_divider.sv
// tb_multicycle_divider
//   Directed-vector bench for multicycle_divider. It uses a WIDTH=32
//   instance and a WIDTH=8 instance that share the clock and reset.
//   Expected values are hand-computed constants.
module tb_multicycle_divider;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // WIDTH=32 instance
   logic        start, signed_op, cancel, result_ack;
   logic [31:0] dividend, divisor;
   logic        stall_request, done;
   logic [31:0] quotient, remainder;

   multicycle_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .cancel(cancel),
      .result_ack(result_ack), .stall_request(stall_request), .done(done),
      .quotient(quotient), .remainder(remainder)
   );

   // WIDTH=8 instance
   logic       start8, signed_op8, cancel8, result_ack8;
   logic [7:0] dividend8, divisor8;
   logic       stall_request8, done8;
   logic [7:0] quotient8, remainder8;

   multicycle_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_op(signed_op8),
      .dividend(dividend8), .divisor(divisor8), .cancel(cancel8),
      .result_ack(result_ack8), .stall_request(stall_request8), .done(done8),
      .quotient(quotient8), .remainder(remainder8)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one divide. The start cycle is cycle 0. The task reports the
   // cycle in which done first appears, checks the results, then acks.
   task automatic run_div(input string tag, input bit w8, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int exp_lat);
      int  cyc;
      bit  stall_ok;
      if (w8) begin
         start8 = 1'b1; signed_op8 = sgn; dividend8 = a[7:0]; divisor8 = b[7:0];
      end else begin
         start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
      end
      #1;
      chk({tag, " stall c0"}, w8 ? 32'(stall_request8) : 32'(stall_request), 32'd1);
      @(posedge clk); #1;
      // Operands change after the start edge; this must not matter.
      if (w8) begin
         start8 = 1'b0; dividend8 = ~a[7:0]; divisor8 = ~b[7:0]; signed_op8 = ~sgn;
      end else begin
         start = 1'b0; dividend = ~a; divisor = ~b; signed_op = ~sgn;
      end
      cyc = 1;
      stall_ok = 1'b1;
      while (!(w8 ? done8 : done) && cyc < 100) begin
         if (!(w8 ? stall_request8 : stall_request)) stall_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, " busy stall"}, 32'(stall_ok), 32'd1);
      chk({tag, " quotient"}, w8 ? 32'(quotient8) : quotient, exp_q);
      chk({tag, " remainder"}, w8 ? 32'(remainder8) : remainder, exp_r);
      chk({tag, " stall in done"}, w8 ? 32'(stall_request8) : 32'(stall_request), 32'd0);
      if (w8) result_ack8 = 1'b1; else result_ack = 1'b1;
      @(posedge clk); #1;
      if (w8) result_ack8 = 1'b0; else result_ack = 1'b0;
      chk({tag, " done after ack"}, w8 ? 32'(done8) : 32'(done), 32'd0);
   endtask

   initial begin
      int seen;
      rst = 1'b0;
      start = 0; signed_op = 0; cancel = 0; result_ack = 0; dividend = 0; divisor = 0;
      start8 = 0; signed_op8 = 0; cancel8 = 0; result_ack8 = 0; dividend8 = 0; divisor8 = 0;
      #12;
      chk("rst done", 32'(done), 32'd0);
      chk("rst quotient", quotient, 32'd0);
      chk("rst remainder", remainder, 32'd0);
      chk("rst stall idle", 32'(stall_request), 32'd0);
      start = 1'b1; #1;
      chk("rst stall follows start", 32'(stall_request), 32'd1);
      start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      run_div("u100/7",   0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
      run_div("s-7/2",    0, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
      run_div("uFFF9/2",  0, 0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33);
      run_div("s7/-2",    0, 1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
      run_div("s ovf",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
      run_div("u5/0",     0, 0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1);
      run_div("s5/0",     0, 1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1);
      run_div("s-8/0",    0, 1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  1);

      // Cancel in BUSY cycle 10.
      start = 1'b1; signed_op = 0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("pre-cancel stall", 32'(stall_request), 32'd1);
      cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      chk("cancel stall", 32'(stall_request), 32'd0);
      seen = 0;
      repeat (40) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      chk("cancel no done", 32'(seen), 32'd0);
      chk("cancel holds quotient", quotient, 32'hFFFF_FFFF);
      run_div("u9/3",     0, 0, 32'd9,          32'd3,          32'd3,          32'd0,          33);

      // Reset in BUSY cycle 5.
      start = 1'b1; signed_op = 0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b0; #1;
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst quotient", quotient, 32'd0);
      chk("midrst remainder", remainder, 32'd0);
      chk("midrst stall", 32'(stall_request), 32'd0);
      @(negedge clk); rst = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("postrst no done", 32'(seen), 32'd0);
      run_div("u1/1",     0, 0, 32'd1,          32'd1,          32'd1,          32'd0,          33);

      // WIDTH=8 instance
      run_div("w8 200/13", 1, 0, 32'd200,       32'd13,         32'd15,         32'd5,          9);
      run_div("w8 s-128/-1", 1, 1, 32'h80,      32'hFF,         32'h80,         32'd0,          9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
